// File: rtl/fifo_write_arbiter.sv
// Round-robin write arbiter: grants one requesting port per cycle with bounded bursts,
// registers the accepted entry into the FIFO write port, and discards entries whose valid bit is clear.
module fifo_write_arbiter #(
   parameter int NumPorts     = 4,
   parameter int EntryWidth   = 85,
   parameter int fifo_lg_size = 12,
   parameter int AFullMargin  = 2,
   parameter int BurstLen     = 4,
   parameter int ValidBitPos  = 81
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic [NumPorts-1:0]              req,
   input  logic [NumPorts*EntryWidth-1:0]   req_data,
   output logic [NumPorts-1:0]              gnt,
   output logic                             fifo_wr_en,
   output logic [EntryWidth-1:0]            fifo_buf_in,
   input  logic                             fifo_buf_full,
   input  logic [fifo_lg_size:0]            fifo_counter,
   output logic [15:0]                      drop_count,
   output logic [$clog2(NumPorts)-1:0]      cur_port,
   output logic                             state_dbg
);

   localparam int PortW    = $clog2(NumPorts);
   localparam int BurstW   = 4;
   localparam int OccW     = fifo_lg_size + 2;
   localparam int FifoSize = 1 << fifo_lg_size;
   localparam logic [OccW-1:0] AFullThresh = OccW'(FifoSize - AFullMargin);

   typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;

   state_t                 state_q, state_d;
   logic [PortW-1:0]       cur_port_q, cur_port_d;
   logic [BurstW-1:0]      burst_q, burst_d;
   logic                   fifo_wr_en_q, fifo_wr_en_d;
   logic [EntryWidth-1:0]  fifo_buf_in_q, fifo_buf_in_d;
   logic [15:0]            drop_count_q, drop_count_d;

   logic [OccW-1:0]        occ;
   logic                   stall;
   logic                   arb_found;
   logic [PortW-1:0]       arb_idx;
   logic                   gnt_en;
   logic [PortW-1:0]       gnt_idx;
   logic [EntryWidth-1:0]  sel_entry;
   logic                   xfer;

   // The write already in flight counts against the reserve so the FIFO never overflows.
   assign occ   = OccW'(fifo_counter) + OccW'(fifo_wr_en_q);
   assign stall = fifo_buf_full || (occ >= AFullThresh);

   // Search from the port after cur_port; while holding, the current owner only wins by re-grant.
   always_comb begin
      arb_found = 1'b0;
      arb_idx   = '0;
      for (int i = 1; i <= NumPorts; i++) begin
         if (!arb_found && req[(int'(cur_port_q) + i) % NumPorts] &&
             !(state_q == HOLD && ((int'(cur_port_q) + i) % NumPorts) == int'(cur_port_q))) begin
            arb_found = 1'b1;
            arb_idx   = PortW'((int'(cur_port_q) + i) % NumPorts);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= IDLE;
         cur_port_q    <= PortW'(NumPorts - 1);
         burst_q       <= '0;
         fifo_wr_en_q  <= 1'b0;
         fifo_buf_in_q <= '0;
         drop_count_q  <= '0;
      end else begin
         state_q       <= state_d;
         cur_port_q    <= cur_port_d;
         burst_q       <= burst_d;
         fifo_wr_en_q  <= fifo_wr_en_d;
         fifo_buf_in_q <= fifo_buf_in_d;
         drop_count_q  <= drop_count_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      cur_port_d = cur_port_q;
      burst_d    = burst_q;
      gnt_en     = 1'b0;
      gnt_idx    = cur_port_q;
      if (!stall) begin
         case (state_q)
            IDLE: begin
               if (arb_found) begin
                  gnt_en     = 1'b1;
                  gnt_idx    = arb_idx;
                  cur_port_d = arb_idx;
                  burst_d    = BurstW'(1);
                  state_d    = HOLD;
               end
            end
            HOLD: begin
               if (req[cur_port_q] && (burst_q < BurstW'(BurstLen))) begin
                  gnt_en  = 1'b1;
                  burst_d = burst_q + BurstW'(1);
               end else if (arb_found) begin
                  gnt_en     = 1'b1;
                  gnt_idx    = arb_idx;
                  cur_port_d = arb_idx;
                  burst_d    = BurstW'(1);
               end else begin
                  state_d = IDLE;
                  burst_d = '0;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_comb begin
      gnt = '0;
      if (gnt_en && !rst) gnt[gnt_idx] = 1'b1;
      sel_entry     = req_data[int'(gnt_idx)*EntryWidth +: EntryWidth];
      xfer          = |gnt;
      fifo_wr_en_d  = xfer && sel_entry[ValidBitPos];
      fifo_buf_in_d = xfer ? sel_entry : fifo_buf_in_q;
      drop_count_d  = drop_count_q;
      if (xfer && !sel_entry[ValidBitPos] && (drop_count_q != 16'hFFFF))
         drop_count_d = drop_count_q + 16'd1;
   end

   assign fifo_wr_en  = fifo_wr_en_q;
   assign fifo_buf_in = fifo_buf_in_q;
   assign drop_count  = drop_count_q;
   assign cur_port    = cur_port_q;
   assign state_dbg   = state_q;

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Directed bench for fifo_write_arbiter: vector table for round-robin/burst behaviour
// plus hand-written sequences for reset, stall thresholds, drops and reset mid-burst.
module tb_fifo_write_arbiter;

   localparam int NP = 4;
   localparam int EW = 85;
   localparam int LG = 12;

   logic              clk = 1'b0;
   logic              rst;
   logic [NP-1:0]     req;
   logic [NP*EW-1:0]  req_data;
   logic [NP-1:0]     gnt;
   logic              fifo_wr_en;
   logic [EW-1:0]     fifo_buf_in;
   logic              fifo_buf_full;
   logic [LG:0]       fifo_counter;
   logic [15:0]       drop_count;
   logic [1:0]        cur_port;
   logic              state_dbg;

   fifo_write_arbiter dut (
      .clk(clk), .rst(rst), .req(req), .req_data(req_data), .gnt(gnt),
      .fifo_wr_en(fifo_wr_en), .fifo_buf_in(fifo_buf_in), .fifo_buf_full(fifo_buf_full),
      .fifo_counter(fifo_counter), .drop_count(drop_count), .cur_port(cur_port),
      .state_dbg(state_dbg)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [NP-1:0] req;
      logic [NP-1:0] exp_gnt;
      logic          exp_wr;
   } vec_t;

   vec_t          vecs[$];
   logic [EW-1:0] exp_q[$];
   int            n_vec  = 0;
   int            n_fail = 0;

   function automatic logic [EW-1:0] make_entry(int p, logic v, int tag);
      return {3'(p), v, 81'(tag * 16 + p)};
   endfunction

   task automatic check(string name, logic [127:0] act, logic [127:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic drive(logic [NP-1:0] r, logic v, int tag);
      req = r;
      for (int p = 0; p < NP; p++) req_data[p*EW +: EW] = make_entry(p, v, tag);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      drive('0, 1'b1, 0);
      fifo_buf_full = 1'b0;
      fifo_counter  = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      exp_q.delete();
   endtask

   task automatic add(logic [NP-1:0] r, logic [NP-1:0] g, logic w);
      vec_t t;
      t.req = r; t.exp_gnt = g; t.exp_wr = w;
      vecs.push_back(t);
   endtask

   initial begin
      rst = 1'b1;
      fifo_buf_full = 1'b0;
      fifo_counter  = '0;
      drive(4'b1111, 1'b1, 0);

      // reset state, with every port requesting
      repeat (2) @(negedge clk);
      #1;
      check("rst_gnt", gnt, 0);
      check("rst_wr_en", fifo_wr_en, 0);
      check("rst_buf_in", fifo_buf_in, 0);
      check("rst_drop", drop_count, 0);
      check("rst_cur_port", cur_port, 3);
      check("rst_state", state_dbg, 0);
      drive('0, 1'b1, 0);
      rst = 1'b0;

      // all ports requesting: bursts of four, rotating 0..3 then back to 0
      for (int k = 0; k < 17; k++)
         add(4'b1111, 4'b0001 << ((k / 4) % 4), (k != 0));
      add(4'b0000, 4'b0000, 1);
      add(4'b0000, 4'b0000, 0);
      // lone port 0: four grants, one idle cycle, then grants resume
      add(4'b0001, 4'b0001, 0);
      add(4'b0001, 4'b0001, 1);
      add(4'b0001, 4'b0001, 1);
      add(4'b0001, 4'b0001, 1);
      add(4'b0001, 4'b0000, 1);
      add(4'b0001, 4'b0001, 0);
      add(4'b0000, 4'b0000, 1);
      add(4'b0000, 4'b0000, 0);
      // owner drops its request mid-burst; hand-over in the same cycle, with wrap
      add(4'b0110, 4'b0010, 0);
      add(4'b0110, 4'b0010, 1);
      add(4'b0100, 4'b0100, 1);
      add(4'b0101, 4'b0100, 1);
      add(4'b0001, 4'b0001, 1);
      add(4'b0000, 4'b0000, 1);
      add(4'b0000, 4'b0000, 0);

      foreach (vecs[v]) begin
         @(negedge clk);
         drive(vecs[v].req, 1'b1, v);
         #1;
         check($sformatf("vec%0d_gnt", v), gnt, vecs[v].exp_gnt);
         check($sformatf("vec%0d_wr_en", v), fifo_wr_en, vecs[v].exp_wr);
         if (vecs[v].exp_wr && exp_q.size() > 0)
            check($sformatf("vec%0d_buf_in", v), fifo_buf_in, exp_q.pop_front());
         for (int p = 0; p < NP; p++)
            if (vecs[v].exp_gnt[p]) exp_q.push_back(make_entry(p, 1'b1, v));
      end

      // almost-full threshold: counter + in-flight write >= 4094 stalls
      do_reset();
      @(negedge clk);
      drive(4'b0001, 1'b1, 100);
      fifo_counter = 13'd4094;
      #1 check("stall_idle_4094", gnt, 0);
      fifo_counter = 13'd4093;
      #1 check("nostall_idle_4093", gnt, 4'b0001);
      @(negedge clk);
      #1 check("stall_inflight_wr", fifo_wr_en, 1);
      check("stall_4093_plus_inflight", gnt, 0);
      fifo_counter = 13'd4092;
      #1 check("nostall_4092_plus_inflight", gnt, 4'b0001);
      fifo_buf_full = 1'b1;
      #1 check("stall_full", gnt, 0);
      @(negedge clk);
      #1 check("stall_hold_no_wr", fifo_wr_en, 0);
      check("stall_hold_state", state_dbg, 1);
      fifo_buf_full = 1'b0;
      fifo_counter  = '0;
      #1 check("stall_release", gnt, 4'b0001);

      // invalid entry from port 2 is granted but dropped
      do_reset();
      @(negedge clk);
      drive(4'b0100, 1'b0, 200);
      #1 check("drop_gnt", gnt, 4'b0100);
      check("drop_count_before", drop_count, 0);
      @(negedge clk);
      drive(4'b0000, 1'b0, 200);
      #1 check("drop_no_wr", fifo_wr_en, 0);
      check("drop_count_after", drop_count, 1);

      // saturation: a steady stream of invalid entries from every port
      drive(4'b1111, 1'b0, 201);
      repeat (65540) @(posedge clk);
      @(negedge clk);
      #1 check("drop_saturated", drop_count, 16'hFFFF);
      check("drop_sat_no_wr", fifo_wr_en, 0);
      drive(4'b0000, 1'b1, 0);

      // reset during a port-1 burst
      do_reset();
      @(negedge clk);
      drive(4'b0010, 1'b1, 300);
      #1 check("mid_gnt_before", gnt, 4'b0010);
      @(negedge clk);
      #1 check("mid_wr_before", fifo_wr_en, 1);
      rst = 1'b1;
      #1 check("mid_rst_wr_en", fifo_wr_en, 0);
      check("mid_rst_gnt", gnt, 0);
      check("mid_rst_cur_port", cur_port, 3);
      @(negedge clk);
      rst = 1'b0;
      #1 check("mid_after_gnt", gnt, 4'b0010);
      check("mid_after_wr_en", fifo_wr_en, 0);
      @(negedge clk);
      drive(4'b0000, 1'b1, 0);
      #1 check("mid_after_buf_in", fifo_buf_in, make_entry(1, 1'b1, 300));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule

// File: doc/fifo_write_arbiter.md
FIFO_WRITE_ARBITER -- requirements
Module: fifo_write_arbiter

Interface
REQ-001 SHALL have parameter NumPorts, default 4, number of requesting ports.
REQ-002 SHALL have parameter EntryWidth, default 85, FIFO entry width: children[84:82], flit[81:0].
REQ-003 SHALL have parameter fifo_lg_size, default 12; FifoSize = 1<<fifo_lg_size.
REQ-004 SHALL have parameter AFullMargin, default 2, free-entry reserve below FifoSize.
REQ-005 SHALL have parameter BurstLen, default 4, max consecutive grants to one port (1..15).
REQ-006 SHALL have parameter ValidBitPos, default 81.
REQ-007 SHALL have clk, input, 1, clock; reset rst, asynchronous, active-high.
REQ-008 SHALL have req, input, NumPorts, per-port write request.
REQ-009 SHALL have req_data, input, NumPorts*EntryWidth, port i entry in bits [i*EntryWidth +: EntryWidth].
REQ-010 SHALL have gnt, output, NumPorts, combinational one-hot accept; entry transfers when req[i] & gnt[i].
REQ-011 SHALL have fifo_wr_en, output, 1, registered FIFO write enable.
REQ-012 SHALL have fifo_buf_in, output, EntryWidth, registered FIFO write data.
REQ-013 SHALL have fifo_buf_full, input, 1, FIFO full flag.
REQ-014 SHALL have fifo_counter, input, fifo_lg_size+1, FIFO occupancy.
REQ-015 SHALL have drop_count, output, 16, count of discarded invalid entries.
REQ-016 SHALL have cur_port, output, log2(NumPorts), last granted port.

Function
REQ-017 SHALL assert at most one gnt bit per cycle, and only for a port with req high.
REQ-018 SHALL stall (gnt all zero) when fifo_buf_full=1 or fifo_counter + fifo_wr_en >= FifoSize - AFullMargin.
REQ-019 SHALL implement states IDLE and HOLD; reset state IDLE.
REQ-020 In IDLE, not stalled, any req: SHALL grant first requesting port searching from cur_port+1 with wrap, set cur_port to it, load burst counter with 1, go HOLD.
REQ-021 In HOLD: if req[cur_port]=1, burst counter < BurstLen, not stalled, SHALL re-grant cur_port and increment counter.
REQ-022 In HOLD: if req[cur_port]=0 or counter = BurstLen, SHALL arbitrate as in IDLE that same cycle, excluding cur_port when other ports request; with no other request, return to IDLE (grant nothing that cycle).
REQ-023 A stall in HOLD SHALL keep state and counter unchanged and grant nothing.
REQ-024 On transfer, SHALL drive fifo_wr_en=1 and fifo_buf_in=entry on the next clock edge (latency 1), else fifo_wr_en=0 with fifo_buf_in held.
REQ-025 An accepted entry with bit ValidBitPos=0 SHALL be granted but not written (fifo_wr_en=0), and drop_count SHALL increment, saturating at 16'hFFFF.
REQ-026 SHALL count HOLD re-grants of dropped entries toward BurstLen as normal grants.
REQ-027 SHALL sustain one write per cycle when not stalled.
REQ-028 Round-robin SHALL guarantee any continuously requesting port a grant within (NumPorts-1)*BurstLen+1 unstalled cycles.

Reset
REQ-029 On rst high, asynchronously: state IDLE, fifo_wr_en=0, fifo_buf_in=0, drop_count=0, cur_port=NumPorts-1, burst counter 0.
REQ-030 gnt SHALL be all zero while rst is high; reset mid-burst SHALL abandon the burst with no write emitted after reset.

Verification
REQ-031 Reset, then req=4'b0001 valid entry held 6 cycles -> gnt=0001 for 4 cycles, 1 idle cycle, then grants resume; fifo_wr_en follows each grant 1 cycle later.
REQ-032 req=4'b1111 steady, BurstLen=4, FIFO empty -> grant sequence port0 x4, port1 x4, port2 x4, port3 x4, port0 ...
REQ-033 fifo_counter=FifoSize-3 with 1 write in flight -> gnt all zero until fifo_counter drops to FifoSize-4 or below.
REQ-034 Port 2 entry with bit81=0 -> gnt[2]=1, fifo_wr_en=0 next cycle, drop_count 0->1; force 65536 drops -> drop_count stays 16'hFFFF.
REQ-035 rst asserted during HOLD with req=4'b0010 -> fifo_wr_en=0 immediately; after release first grant is port1 (search from port0, which is not requesting).
